// File: rtl/fb_frame_scheduler.sv
// Frame sequencer for the double-buffered framebuffer: clears the back buffer,
// hands the write port to the rasterizer, then swaps on the next vsync fall.
module fb_frame_scheduler #(
    parameter int ADDR_WIDTH = 17,
    parameter int H_RES      = 320,
    parameter int V_RES      = 240
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vsync,
    input  logic                  frame_start,
    input  logic [7:0]            clear_color,
    input  logic                  px_valid,
    input  logic [ADDR_WIDTH-1:0] px_addr,
    input  logic [7:0]            px_data,
    output logic                  px_ready,
    input  logic                  frame_done,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [7:0]            dina,
    output logic                  swap,
    output logic                  busy,
    output logic [15:0]           frame_count
);

    localparam int NPIX = H_RES * V_RES;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
    // One extra bit so the range check stays correct even if NPIX == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0]   NPIX_EXT  = (ADDR_WIDTH + 1)'(NPIX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DRAW,
        S_WAIT_VSYNC,
        S_SWAP
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] clr_cnt_q;
    logic [7:0]            color_q;
    logic                  wea_q;
    logic [ADDR_WIDTH-1:0] addra_q;
    logic [7:0]            dina_q;
    logic                  swap_q;
    logic [15:0]           frame_count_q;

    logic vs_meta_q;
    logic vs_sync_q;
    logic vs_prev_q;
    logic vs_fall_q;

    // vsync crosses from the pixel clock: two-flop synchronizer, then a
    // registered falling-edge pulse that is only honoured in WAIT_VSYNC.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_meta_q <= 1'b0;
            vs_sync_q <= 1'b0;
            vs_prev_q <= 1'b0;
            vs_fall_q <= 1'b0;
        end else begin
            vs_meta_q <= vsync;
            vs_sync_q <= vs_meta_q;
            vs_prev_q <= vs_sync_q;
            vs_fall_q <= vs_prev_q & ~vs_sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            clr_cnt_q     <= '0;
            color_q       <= 8'd0;
            wea_q         <= 1'b0;
            addra_q       <= '0;
            dina_q        <= 8'd0;
            swap_q        <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            wea_q   <= 1'b0;
            addra_q <= '0;
            dina_q  <= 8'd0;
            swap_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        color_q   <= clear_color;
                        clr_cnt_q <= '0;
                        state_q   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    wea_q     <= 1'b1;
                    addra_q   <= clr_cnt_q;
                    dina_q    <= color_q;
                    clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_q <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    // Out-of-range pixels are consumed without a write.
                    if (px_valid && ({1'b0, px_addr} < NPIX_EXT)) begin
                        wea_q   <= 1'b1;
                        addra_q <= px_addr;
                        dina_q  <= px_data;
                    end
                    if (frame_done) begin
                        state_q <= S_WAIT_VSYNC;
                    end
                end
                S_WAIT_VSYNC: begin
                    if (vs_fall_q) begin
                        swap_q        <= 1'b1;
                        frame_count_q <= frame_count_q + 16'd1;
                        state_q       <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign px_ready    = (state_q == S_DRAW);
    assign busy        = (state_q != S_IDLE);
    assign wea         = wea_q;
    assign addra       = addra_q;
    assign dina        = dina_q;
    assign swap        = swap_q;
    assign frame_count = frame_count_q;

endmodule

// File: doc/fb_frame_scheduler.md
# fb_frame_scheduler

Sequences each rendered frame through the double-buffered framebuffer, and owns the framebuffer GPU write port (`wea`/`addra`/`dina`). For each frame it clears the back buffer to a background colour, then gives the write port to the rasterizer until it reports the frame complete. It then waits for the next vsync falling edge and issues a single-cycle `swap`. The framebuffer toggles its front/back selection only on `swap`, so it never flips onto a half-drawn buffer.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: framebuffer address width.
- `H_RES`, 320: pixels per line.
- `V_RES`, 240: lines per frame.
- Derived constant `NPIX = H_RES*V_RES` (76800).

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: reset, synchronous, active-high.
- `vsync` in 1: VGA vsync from the 25 MHz pixel domain; asynchronous to `clk`.
- `frame_start` in 1: pulse requesting a new frame.
- `clear_color` in 8: background colour; sampled on the cycle `frame_start` is accepted.
- `px_valid` in 1: rasterizer pixel write valid.
- `px_addr` in ADDR_WIDTH: pixel address.
- `px_data` in 8: pixel colour.
- `px_ready` out 1: pixel accept; high only in DRAW.
- `frame_done` in 1: rasterizer finished the frame.
- `wea` out 1: framebuffer write enable.
- `addra` out ADDR_WIDTH: framebuffer write address.
- `dina` out 8: framebuffer write data.
- `swap` out 1: one-cycle buffer-swap pulse.
- `busy` out 1: high in any state other than IDLE.
- `frame_count` out 16: count of completed swaps; wraps.

## Operation
- States: IDLE, CLEAR, DRAW, WAIT_VSYNC, SWAP.
- **IDLE**
  - `frame_start`=1: latch `clear_color`, set the clear counter to 0, go to CLEAR.
  - `frame_start` in any other state is ignored.
- **CLEAR**
  - Each cycle: write `clear_color` to address = counter, then counter+1.
  - After writing address NPIX-1, go to DRAW.
  - Exactly NPIX writes, contiguous, ascending. `px_ready`=0 for the whole state.
- **DRAW**
  - `px_ready`=1. A pixel is accepted when `px_valid & px_ready`.
  - Accepted pixel with `px_addr` < NPIX: produces a write.
  - Accepted pixel with `px_addr` ≥ NPIX: consumed, no write (`wea`=0).
  - `frame_done`=1: go to WAIT_VSYNC. A pixel accepted in the same cycle is still written.
- **WAIT_VSYNC**
  - `vsync` passes through a 2-flop synchronizer, then a falling-edge detector (previous synced=1, current synced=0).
  - On the detected edge, go to SWAP.
  - Edges detected in any other state are discarded. They are never queued.
- **SWAP**
  - `swap`=1 for exactly one cycle, `frame_count`+1, then go to IDLE.
- Write-port outputs (`wea`/`addra`/`dina`) are registered.
  - When not writing: `wea`=0, `addra`=0, `dina`=0.
- Counter widths:
  - Clear counter is ADDR_WIDTH bits; the compare is against NPIX-1.
  - `frame_count` wraps from 0xFFFF to 0.
- `px_addr` is never modified: no clamping and no wrap.

## Timing
- Reset values: state IDLE; `wea`, `addra`, `dina`, `swap`, `px_ready`, `busy` all 0; `frame_count`=0; synchronizer and edge-detect flops 0; clear counter 0.
- `rst` mid-frame:
  - Abort on the next edge to IDLE, with no further writes.
  - No `swap` for the aborted frame.
- `px_ready` and `busy` are combinational from state.
- Write latency:
  - Accepted pixel at cycle N: `wea`/`addra`/`dina` valid at cycle N+1.
  - Clear write k is issued at cycle (CLEAR entry + k + 1).
- `frame_start` at cycle N:
  - CLEAR entered at N+1.
  - DRAW entered at N+1+NPIX.
- vsync latency: a `vsync` fall sampled at cycle N asserts `swap` at N+3 (2 sync flops + edge register + SWAP state). Tolerance is ±1 cycle for async sampling.
- `frame_done` and a vsync edge in the same cycle while in DRAW: the edge is ignored; the block waits for the next falling edge.
- `frame_start` in the SWAP cycle is ignored. A new frame needs `frame_start` in IDLE, i.e. at or after SWAP+1.

## Test plan
- Reset then `frame_start` with `clear_color`=0x1C:
  - Exactly 76800 writes with `dina`=0x1C, `addra` running 0..76799 contiguously.
  - `px_ready`=0 throughout CLEAR.
  - DRAW entered on the cycle after the last write.
- DRAW pixel handling:
  - `px_valid` with addr 0x00123 / data 0xE0: `wea`=1, `addra`=0x00123, `dina`=0xE0 one cycle later.
  - addr 76800: accepted, `wea` stays 0.
- `frame_done`, then a vsync high→low:
  - `swap` pulses exactly one cycle, 3±1 cycles after the edge.
  - `frame_count` goes 0→1, state returns to IDLE.
- Stray vsync edges:
  - Vsync edges during CLEAR and DRAW produce no `swap`.
  - Two edges during WAIT_VSYNC produce exactly one `swap`.
- `rst` asserted mid-CLEAR at address 500:
  - `wea` is 0 from the next cycle; all outputs return to reset values.
  - A later `frame_start` clears again starting from address 0.
- Edge-case handshakes:
  - `frame_done` in the same cycle as an accepted pixel: that pixel is written.
  - `frame_start` while busy: ignored.
